matmul_sequencer: RTL and testbench
===================================

# matmul_sequencer

Control and arithmetic sequencer for the SPI-loaded matrix multiplier. After the SPI front end has written operand matrices A and B into the operand register file, it pulses `start`; this block walks every output element in row-major order. For each element it issues operand reads, multiply-accumulates the returned bytes and writes the result into the C register file, which the front end then shifts out. `ready` from this block is the design-level ready pin.

## Interface

Parameters:
- `N`, default 3: matrix dimension, legal 2..4.
- `W`, default 8: unsigned element width.

Ports:
- `hz100`, in, 1: system clock; all logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a multiply. Sampled only in IDLE.
- `abort`, in, 1: synchronous cancel of a run in progress.
- `ready`, out, 1: high in IDLE only.
- `done`, out, 1: one-cycle pulse when all N*N results have been written.
- `rd_en`, out, 1: operand read strobe.
- `a_addr`, out, 4: A index, i*N+k.
- `b_addr`, out, 4: B index, k*N+j.
- `a_data`, in, W: A read data. Valid the cycle after `rd_en`.
- `b_data`, in, W: B read data. Valid the cycle after `rd_en`.
- `c_we`, out, 1: result write strobe.
- `c_addr`, out, 4: C index, i*N+j.
- `c_data`, out, 2W+2: result value.

## Operation

- **States:** IDLE, ISSUE, ACC, WRITE, DONE.
- **Counters:** i, j, k, each 2 bits. Loop order is i outer, then j, then k inner.
- **IDLE:**
  - `ready`=1.
  - `start`=1 and `abort`=0 → ISSUE, with i=j=k=0.
- **ISSUE:**
  - `rd_en`=1, `a_addr`=i*N+k, `b_addr`=k*N+j.
  - → ACC.
- **ACC:**
  - Accumulator update: acc ← a_data*b_data if k==0, else acc + a_data*b_data. Unsigned arithmetic.
  - The product is 2W bits, zero-extended to 2W+2 bits.
  - k<N-1 → k++, ISSUE. Otherwise → WRITE.
- **WRITE:**
  - `c_we`=1, `c_addr`=i*N+j, `c_data`=acc.
  - Then k←0 and advance j; when j wraps, advance i.
  - If (i,j)==(N-1,N-1) → DONE, else → ISSUE.
- **DONE:** `done`=1 → IDLE.
- **Output hold rules:**
  - `a_addr`/`b_addr` are meaningful only while `rd_en`=1.
  - `c_addr`/`c_data` are meaningful only while `c_we`=1.
  - All three hold their last value otherwise.
- **Overflow:** none possible. The maximum sum is N*(2^W-1)^2, below 2^(2W+2) for N≤4.
- **`start` while not IDLE:** ignored. No restart, no effect on counters.
- **`abort`:**
  - `abort`=1 in any non-IDLE state → IDLE at the next edge.
  - A WRITE cycle coinciding with `abort` still asserts `c_we` in that cycle, since it is combinational from state. No further writes and no `done` follow.
  - `abort` and `start` together in IDLE: `abort` wins, stay IDLE.
- **`reset`:**
  - Forces IDLE at the next edge and clears acc, i, j, k.
  - Clears all address/data outputs to 0.
  - `done`, `rd_en` and `c_we` go to 0. `ready` goes to 1.
  - Reset mid-run leaves C partially written; this is not an error.

## Timing

- **Output decode:** `rd_en`, `c_we`, `done` and `ready` are Moore decodes of the registered state. There are no combinational paths from inputs.
- **Per-element cost:** 2N+1 cycles, i.e. N×(ISSUE, ACC) plus one WRITE.
- **Run length:** `start` sampled high in IDLE at cycle t gives:
  - first ISSUE at t+1;
  - `done` at t+1+N*N*(2N+1);
  - `ready` back at the following cycle.
  - For N=3: `done` at t+64, `ready` at t+65.
- **`ready`:** low from t+1 through the DONE cycle inclusive.
- **Write order:** C writes occur in increasing `c_addr` order, 0..N*N-1, one per 2N+1 cycles. The first write is at t+2N+1.
- **Read latency:** operand read latency is exactly 1 cycle. The block captures `a_data`/`b_data` only in ACC.
- **Back-to-back runs:** `start` asserted in the first `ready` cycle is accepted. There is no minimum idle gap.

## Test plan

- **Identity:** N=3, A=identity, B=1..9 row-major, `start` at cycle t → nine `c_we` pulses, `c_addr` 0..8, `c_data` 1..9. `done` at t+64; `ready` at t+65.
- **Full-scale:** all A, B elements 255 → every `c_data`=195075 (0x2FA03), no truncation. Also check `a_addr`/`b_addr` sequence 0/0, 1/3, 2/6 for element 0.
- **Start while busy:** pulse `start` again at t+10 and t+40 → identical writes and timing to a single start; exactly one `done`.
- **Abort:** assert `abort` in the cycle after the third `c_we` → no further `c_we`, no `done`, `ready`=1 next cycle. A new `start` then produces the complete correct nine-element result.
- **Reset mid-run:** `reset` at cycle t+20 → next edge gives `ready`=1, `done`=`rd_en`=`c_we`=0 and all addr/data outputs 0. A subsequent run matches the identity case exactly.
- **Back-to-back with N=2:** second `start` in the first `ready` cycle → second run accepted. `done` spacing is 1+4*5+1=22 cycles, and the results of both runs are correct.

Source files
------------

// File: rtl/matmul_sequencer.sv
// Sequencer for the SPI-loaded matrix multiplier: walks C = A*B in row-major
// order, issuing operand reads, accumulating products and writing results.
module matmul_sequencer #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 8
) (
  input  logic             hz100,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             ready,
  output logic             done,
  output logic             rd_en,
  output logic [3:0]       a_addr,
  output logic [3:0]       b_addr,
  input  logic [W-1:0]     a_data,
  input  logic [W-1:0]     b_data,
  output logic             c_we,
  output logic [3:0]       c_addr,
  output logic [2*W+1:0]   c_data
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned AW = 2 * W + 2;
  localparam logic [1:0]  LAST = 2'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ACC   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [1:0]      i, j, k;
  logic [1:0]      i_n, j_n, k_n;
  logic [AW-1:0]   acc, acc_n;
  logic [PW-1:0]   prod;
  logic [AW-1:0]   prod_ext;

  logic            ready_n, done_n, rd_en_n, c_we_n;
  logic [3:0]      a_addr_n, b_addr_n, c_addr_n;
  logic [AW-1:0]   c_data_n;

  // Flat row-major index r*N+c into a 16-entry register file.
  function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] c);
    return 4'(32'(r) * N + 32'(c));
  endfunction

  assign prod     = PW'(a_data) * PW'(b_data);
  assign prod_ext = AW'(prod);

  // State, loop counters and accumulator.
  always_ff @(posedge hz100) begin
    if (reset) begin
      state <= S_IDLE;
      i     <= 2'd0;
      j     <= 2'd0;
      k     <= 2'd0;
      acc   <= '0;
    end else begin
      state <= state_n;
      i     <= i_n;
      j     <= j_n;
      k     <= k_n;
      acc   <= acc_n;
    end
  end

  // Next state, counter advance and multiply-accumulate.
  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    k_n     = k;
    acc_n   = acc;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_n = S_ISSUE;
          i_n     = 2'd0;
          j_n     = 2'd0;
          k_n     = 2'd0;
        end
      end
      S_ISSUE: state_n = S_ACC;
      S_ACC: begin
        acc_n = (k == 2'd0) ? prod_ext : acc + prod_ext;
        if (k < LAST) begin
          k_n     = k + 2'd1;
          state_n = S_ISSUE;
        end else begin
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        k_n = 2'd0;
        if (j == LAST) begin
          j_n = 2'd0;
          i_n = i + 2'd1;
        end else begin
          j_n = j + 2'd1;
        end
        state_n = (i == LAST && j == LAST) ? S_DONE : S_ISSUE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (abort && state != S_IDLE) state_n = S_IDLE;
  end

  // Output values for the coming cycle; addresses and data hold between strobes.
  always_comb begin
    ready_n  = (state_n == S_IDLE);
    done_n   = (state_n == S_DONE);
    rd_en_n  = (state_n == S_ISSUE);
    c_we_n   = (state_n == S_WRITE);
    a_addr_n = a_addr;
    b_addr_n = b_addr;
    c_addr_n = c_addr;
    c_data_n = c_data;
    if (state_n == S_ISSUE) begin
      a_addr_n = idx(i_n, k_n);
      b_addr_n = idx(k_n, j_n);
    end
    if (state_n == S_WRITE) begin
      c_addr_n = idx(i_n, j_n);
      c_data_n = acc_n;
    end
  end

  // Output registers, so every strobe is a clean decode of the current state.
  always_ff @(posedge hz100) begin
    if (reset) begin
      ready  <= 1'b1;
      done   <= 1'b0;
      rd_en  <= 1'b0;
      c_we   <= 1'b0;
      a_addr <= 4'd0;
      b_addr <= 4'd0;
      c_addr <= 4'd0;
      c_data <= '0;
    end else begin
      ready  <= ready_n;
      done   <= done_n;
      rd_en  <= rd_en_n;
      c_we   <= c_we_n;
      a_addr <= a_addr_n;
      b_addr <= b_addr_n;
      c_addr <= c_addr_n;
      c_data <= c_data_n;
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: N=3 instance for the main scenarios,
// N=2 instance for back-to-back runs; operand files modelled with 1-cycle latency.
module tb_matmul_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  logic reset, start, abort, start2, abort2;

  logic        ready, done, rd_en, c_we;
  logic [3:0]  a_addr, b_addr, c_addr;
  logic [7:0]  a_data, b_data;
  logic [17:0] c_data;

  logic        ready2, done2, rd_en2, c_we2;
  logic [3:0]  a_addr2, b_addr2, c_addr2;
  logic [7:0]  a_data2, b_data2;
  logic [17:0] c_data2;

  matmul_sequencer #(.N(3), .W(8)) u3 (
    .hz100(clk), .reset(reset), .start(start), .abort(abort),
    .ready(ready), .done(done), .rd_en(rd_en),
    .a_addr(a_addr), .b_addr(b_addr), .a_data(a_data), .b_data(b_data),
    .c_we(c_we), .c_addr(c_addr), .c_data(c_data)
  );

  matmul_sequencer #(.N(2), .W(8)) u2 (
    .hz100(clk), .reset(reset), .start(start2), .abort(abort2),
    .ready(ready2), .done(done2), .rd_en(rd_en2),
    .a_addr(a_addr2), .b_addr(b_addr2), .a_data(a_data2), .b_data(b_data2),
    .c_we(c_we2), .c_addr(c_addr2), .c_data(c_data2)
  );

  logic [7:0] ma3 [16];
  logic [7:0] mb3 [16];
  logic [7:0] ma2 [16];
  logic [7:0] mb2 [16];

  logic [3:0]  wa3 [$];
  logic [17:0] wd3 [$];
  int          wc3 [$];
  int          dn3 [$];
  logic [3:0]  ra3 [$];
  logic [3:0]  rb3 [$];
  logic [3:0]  wa2 [$];
  logic [17:0] wd2 [$];

  logic       pend3 = 1'b0, pend2 = 1'b0;
  logic [3:0] pa3 = 4'd0, pb3 = 4'd0, pa2 = 4'd0, pb2 = 4'd0;

  // Operand files answer one cycle after rd_en; junk otherwise. Also logs traffic.
  always @(negedge clk) begin
    if (pend3) begin a_data = ma3[pa3]; b_data = mb3[pb3]; end
    else begin a_data = 8'hC3; b_data = 8'h5A; end
    pend3 = rd_en; pa3 = a_addr; pb3 = b_addr;
    if (rd_en) begin ra3.push_back(a_addr); rb3.push_back(b_addr); end
    if (c_we) begin wa3.push_back(c_addr); wd3.push_back(c_data); wc3.push_back(cyc); end
    if (done) dn3.push_back(cyc);

    if (pend2) begin a_data2 = ma2[pa2]; b_data2 = mb2[pb2]; end
    else begin a_data2 = 8'h3C; b_data2 = 8'hA5; end
    pend2 = rd_en2; pa2 = a_addr2; pb2 = b_addr2;
    if (c_we2) begin wa2.push_back(c_addr2); wd2.push_back(c_data2); end
  end

  task automatic clear_logs();
    wa3.delete(); wd3.delete(); wc3.delete(); dn3.delete(); ra3.delete(); rb3.delete();
  endtask

  task automatic load_identity();
    for (int n = 0; n < 16; n++) begin
      ma3[n] = (n < 9 && n % 4 == 0) ? 8'd1 : 8'd0;
      mb3[n] = (n < 9) ? 8'(n + 1) : 8'd0;
    end
  endtask

  // Identity run with optional extra start pulses at t0+x1 / t0+x2 (0 = none).
  task automatic run_identity(input string tag, input int x1, input int x2);
    int t0, tdone;
    bit ready_bad;
    load_identity();
    clear_logs();
    @(negedge clk); start = 1'b1; t0 = cyc;
    tdone = -1; ready_bad = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      start = ((x1 != 0) && (cyc == t0 + x1)) || ((x2 != 0) && (cyc == t0 + x2));
      if (done) begin tdone = cyc; break; end
      if (ready) ready_bad = 1'b1;
    end
    start = 1'b0;
    tests_run++;
    if (tdone !== t0 + 64) begin tests_failed++; $display("FAIL %s done_cycle: got %0d expected %0d", tag, tdone - t0, 64); end
    tests_run++;
    if (ready_bad !== 1'b0) begin tests_failed++; $display("FAIL %s ready_low_during_run: got %0d expected 0", tag, ready_bad); end
    @(negedge clk);
    tests_run++;
    if (ready !== 1'b1) begin tests_failed++; $display("FAIL %s ready_after_done: got %0d expected 1", tag, ready); end
    repeat (12) @(negedge clk);
    tests_run++;
    if (wa3.size() !== 9) begin tests_failed++; $display("FAIL %s write_count: got %0d expected 9", tag, wa3.size()); end
    for (int n = 0; n < wa3.size() && n < 9; n++) begin
      tests_run++;
      if (wa3[n] !== 4'(n) || wd3[n] !== 18'(n + 1) || wc3[n] !== t0 + 7 * (n + 1)) begin
        tests_failed++;
        $display("FAIL %s write%0d: got addr=%0d data=%0d cyc=+%0d expected addr=%0d data=%0d cyc=+%0d",
                 tag, n, wa3[n], wd3[n], wc3[n] - t0, n, n + 1, 7 * (n + 1));
      end
    end
    tests_run++;
    if (dn3.size() !== 1) begin tests_failed++; $display("FAIL %s done_pulses: got %0d expected 1", tag, dn3.size()); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({ready, done, rd_en, c_we} !== 4'b1000) begin tests_failed++; $display("FAIL reset_strobes: got %b expected 1000", {ready, done, rd_en, c_we}); end
    tests_run++;
    if ({a_addr, b_addr, c_addr} !== 12'd0 || c_data !== 18'd0) begin
      tests_failed++; $display("FAIL reset_outputs: got a=%0d b=%0d c=%0d d=%0d expected all 0", a_addr, b_addr, c_addr, c_data);
    end
    tests_run++;
    if (ready2 !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_n2: got %0d expected 1", ready2); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (ready !== 1'b1 || rd_en !== 1'b0) begin tests_failed++; $display("FAIL idle_after_reset: got ready=%0d rd_en=%0d expected 1/0", ready, rd_en); end
  endtask

  task automatic test_identity();
    run_identity("identity", 0, 0);
  endtask

  task automatic test_full_scale();
    int tdone;
    logic [3:0] ea [4];
    logic [3:0] eb [4];
    ea = '{4'd0, 4'd1, 4'd2, 4'd0};
    eb = '{4'd0, 4'd3, 4'd6, 4'd1};
    for (int n = 0; n < 16; n++) begin ma3[n] = 8'd255; mb3[n] = 8'd255; end
    clear_logs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    tdone = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done) begin tdone = cyc; break; end
    end
    @(negedge clk);
    tests_run++;
    if (tdone < 0 || wd3.size() !== 9) begin tests_failed++; $display("FAIL full_writes: got %0d expected 9 (done seen %0d)", wd3.size(), tdone >= 0); end
    for (int n = 0; n < wd3.size() && n < 9; n++) begin
      tests_run++;
      if (wd3[n] !== 18'd195075) begin tests_failed++; $display("FAIL full_data%0d: got %0d expected 195075", n, wd3[n]); end
    end
    tests_run++;
    if (ra3.size() !== 27) begin tests_failed++; $display("FAIL full_read_count: got %0d expected 27", ra3.size()); end
    for (int n = 0; n < 4 && n < ra3.size(); n++) begin
      tests_run++;
      if (ra3[n] !== ea[n] || rb3[n] !== eb[n]) begin
        tests_failed++; $display("FAIL full_read%0d: got a=%0d b=%0d expected a=%0d b=%0d", n, ra3[n], rb3[n], ea[n], eb[n]);
      end
    end
  endtask

  task automatic test_start_busy();
    run_identity("start_busy", 10, 40);
  endtask

  task automatic test_abort();
    int nwe;
    bit found;
    // start and abort together in IDLE: abort wins
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    tests_run++;
    if (ready !== 1'b1 || rd_en !== 1'b0) begin tests_failed++; $display("FAIL start_abort_idle: got ready=%0d rd_en=%0d expected 1/0", ready, rd_en); end

    load_identity();
    clear_logs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    nwe = 0; found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c_we) nwe++;
      if (nwe == 3) begin found = 1'b1; break; end
      @(negedge clk);
    end
    tests_run++;
    if (!found) begin tests_failed++; $display("FAIL abort_third_write: got %0d writes expected 3", nwe); end
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    tests_run++;
    if ({ready, rd_en, c_we, done} !== 4'b1000) begin tests_failed++; $display("FAIL abort_idle: got %b expected 1000", {ready, rd_en, c_we, done}); end
    repeat (80) @(negedge clk);
    tests_run++;
    if (wa3.size() !== 3) begin tests_failed++; $display("FAIL abort_writes: got %0d expected 3", wa3.size()); end
    tests_run++;
    if (dn3.size() !== 0) begin tests_failed++; $display("FAIL abort_done: got %0d expected 0", dn3.size()); end
    run_identity("post_abort", 0, 0);
  endtask

  task automatic test_reset_midrun();
    load_identity();
    clear_logs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({ready, done, rd_en, c_we} !== 4'b1000) begin tests_failed++; $display("FAIL midrun_reset_strobes: got %b expected 1000", {ready, done, rd_en, c_we}); end
    tests_run++;
    if ({a_addr, b_addr, c_addr} !== 12'd0 || c_data !== 18'd0) begin
      tests_failed++; $display("FAIL midrun_reset_outputs: got a=%0d b=%0d c=%0d d=%0d expected all 0", a_addr, b_addr, c_addr, c_data);
    end
    tests_run++;
    if (wa3.size() !== 2) begin tests_failed++; $display("FAIL midrun_partial_writes: got %0d expected 2", wa3.size()); end
    reset = 1'b0;
    run_identity("post_reset", 0, 0);
  endtask

  task automatic test_back_to_back();
    int t0, d1, d2;
    logic [17:0] exp_d [8];
    exp_d = '{18'd19, 18'd22, 18'd43, 18'd50, 18'd1, 18'd2, 18'd3, 18'd4};
    for (int n = 0; n < 16; n++) begin
      ma2[n] = (n < 4) ? 8'(n + 1) : 8'd0;
      mb2[n] = (n < 4) ? 8'(n + 5) : 8'd0;
    end
    wa2.delete(); wd2.delete();
    @(negedge clk); start2 = 1'b1; t0 = cyc;
    @(negedge clk); start2 = 1'b0;
    d1 = -1;
    for (int c = 0; c < 60; c++) begin
      if (done2) begin d1 = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    tests_run++;
    if (ready2 !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready: got %0d expected 1", ready2); end
    start2 = 1'b1;
    for (int n = 0; n < 4; n++) mb2[n] = (n == 0 || n == 3) ? 8'd1 : 8'd0;
    @(negedge clk); start2 = 1'b0;
    tests_run++;
    if (ready2 !== 1'b0 || rd_en2 !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept: got ready=%0d rd_en=%0d expected 0/1", ready2, rd_en2); end
    d2 = -1;
    for (int c = 0; c < 60; c++) begin
      if (done2) begin d2 = cyc; break; end
      @(negedge clk);
    end
    tests_run++;
    if (d1 !== t0 + 21) begin tests_failed++; $display("FAIL b2b_first_done: got %0d expected %0d", d1 - t0, 21); end
    tests_run++;
    if (d2 - d1 !== 22 || d1 < 0 || d2 < 0) begin tests_failed++; $display("FAIL b2b_done_spacing: got %0d expected 22", d2 - d1); end
    @(negedge clk);
    tests_run++;
    if (wd2.size() !== 8) begin tests_failed++; $display("FAIL b2b_write_count: got %0d expected 8", wd2.size()); end
    for (int n = 0; n < 8 && n < wd2.size(); n++) begin
      tests_run++;
      if (wa2[n] !== 4'(n % 4) || wd2[n] !== exp_d[n]) begin
        tests_failed++; $display("FAIL b2b_write%0d: got addr=%0d data=%0d expected addr=%0d data=%0d", n, wa2[n], wd2[n], n % 4, exp_d[n]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
    for (int n = 0; n < 16; n++) begin ma3[n] = 8'd0; mb3[n] = 8'd0; ma2[n] = 8'd0; mb2[n] = 8'd0; end
    test_reset();
    test_identity();
    test_full_scale();
    test_start_busy();
    test_abort();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
